// File: rtl/aq_spsram_64x88_ctrl.sv
// Single-port SRAM controller: clears all entries after reset, then round-robins write/read requests onto one port.
// Latency: a write goes to the SRAM pins in its accept cycle; read data is valid 2 cycles after the read is accepted.
// Backpressure: both rdy are low during the clear sweep; a tie goes to the port not granted last; read data cannot be stalled.
module aq_spsram_64x88_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 88
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  init_req,
    input  logic                  wr_req_vld,
    output logic                  wr_req_rdy,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [1:0]            wr_half_en,
    input  logic                  rd_req_vld,
    output logic                  rd_req_rdy,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_data_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam int HALF = DATA_WIDTH / 2;

    typedef enum logic { ST_INIT = 1'b0, ST_RUN = 1'b1 } state_t;
    typedef enum logic { GNT_RD = 1'b0, GNT_WR = 1'b1 } grant_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q;
    logic [ADDR_WIDTH-1:0] init_cnt_d;
    grant_t                last_grant_q;
    logic                  rd_pend_q;
    logic                  rd_data_vld_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  in_run;
    logic                  wr_fire;
    logic                  rd_fire;

    assign in_run    = (state_q == ST_RUN);
    assign init_done = in_run;

    // Ready never looks at the port's own valid, only at the competitor and the last grant.
    assign wr_req_rdy = in_run && (!rd_req_vld || (last_grant_q == GNT_RD));
    assign rd_req_rdy = in_run && (!wr_req_vld || (last_grant_q == GNT_WR));

    // The two rdy terms are mutually exclusive when both vld are high, so at most one fires.
    assign wr_fire = wr_req_vld && wr_req_rdy;
    assign rd_fire = rd_req_vld && rd_req_rdy;

    // Next state: sweep the counter through every entry, return to the sweep on init_req from RUN.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
                if (init_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (init_req) begin
                    state_d    = ST_INIT;
                    init_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = '0;
            end
        endcase
    end

    // State and sweep counter registers.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Remember which port won last so the next tie goes the other way.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            last_grant_q <= GNT_RD;
        end else if (wr_fire) begin
            last_grant_q <= GNT_WR;
        end else if (rd_fire) begin
            last_grant_q <= GNT_RD;
        end
    end

    // SRAM pin drive: idle while held in reset, clear-write during the sweep, else the firing request.
    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;
        if (!cpurst_b) begin
            sram_cen = 1'b1;
        end else if (state_q == ST_INIT) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = init_cnt_q;
        end else if (wr_fire) begin
            sram_cen             = 1'b0;
            sram_gwen            = 1'b0;
            sram_a               = wr_addr;
            sram_d               = wr_data;
            sram_wen[HALF-1:0]   = {HALF{~wr_half_en[0]}};
            sram_wen[DATA_WIDTH-1:HALF] = {(DATA_WIDTH-HALF){~wr_half_en[1]}};
        end else if (rd_fire) begin
            sram_cen = 1'b0;
            sram_a   = rd_addr;
        end
    end

    // Read return pipe: one cycle for the SRAM access, one for the capture register; keeps running through a re-sweep.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_pend_q     <= 1'b0;
            rd_data_vld_q <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            rd_pend_q     <= rd_fire;
            rd_data_vld_q <= rd_pend_q;
            if (rd_pend_q) begin
                rd_data_q <= sram_q;
            end
        end
    end

    assign rd_data_vld = rd_data_vld_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_aq_spsram_64x88_ctrl.sv
// Bench for aq_spsram_64x88_ctrl: directed vector table plus sweep, re-init and reset corner sequences.
// Drives inputs 1 time unit after the rising edge and checks on the falling edge.
// Includes a behavioural single-port SRAM with 1-cycle read latency and per-bit write enables.
module tb_aq_spsram_64x88_ctrl;

    localparam logic [87:0] W0 = '0;
    localparam logic [87:0] W1 = '1;
    localparam logic [87:0] HI = {{44{1'b1}}, {44{1'b0}}};
    localparam logic [87:0] LO = {{44{1'b0}}, {44{1'b1}}};
    localparam logic [87:0] DA = 88'hAB_0123_4567_89AB_CDEF_00CD;
    localparam logic [87:0] D9 = 88'h12_3456_789A_BCDE_F013_579B;

    logic        clk = 1'b0;
    logic        cpurst_b;
    logic        init_req;
    logic        wr_req_vld, wr_req_rdy;
    logic [5:0]  wr_addr;
    logic [87:0] wr_data;
    logic [1:0]  wr_half_en;
    logic        rd_req_vld, rd_req_rdy;
    logic [5:0]  rd_addr;
    logic        rd_data_vld;
    logic [87:0] rd_data;
    logic        init_done;
    logic [5:0]  sram_a;
    logic        sram_cen, sram_gwen;
    logic [87:0] sram_wen, sram_d, sram_q;

    int n_chk = 0;
    int n_err = 0;

    aq_spsram_64x88_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(88)) dut (
        .forever_cpuclk(clk), .cpurst_b(cpurst_b), .init_req(init_req),
        .wr_req_vld(wr_req_vld), .wr_req_rdy(wr_req_rdy), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_half_en(wr_half_en),
        .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy), .rd_addr(rd_addr),
        .rd_data_vld(rd_data_vld), .rd_data(rd_data), .init_done(init_done),
        .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
        .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM, preloaded with junk so the clear sweep is visible.
    logic [87:0] mem [64];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = {22{4'hA}} ^ 88'(i + 1);
        sram_q = '0;
    end
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q      <= mem[sram_a];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the end, required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        init_req = 1'b0; wr_req_vld = 1'b0; rd_req_vld = 1'b0;
        wr_addr = '0; wr_data = '0; wr_half_en = '0; rd_addr = '0;
    endtask

    // 64 clear-write cycles from address 0, then one RUN cycle checking init_done.
    task automatic do_sweep(input int ireq_at, input bit drv_vld, input int vld_at, input logic [87:0] vld_data);
        for (int i = 0; i < 64; i++) begin
            init_req   = (i == ireq_at);
            wr_req_vld = drv_vld; rd_req_vld = drv_vld;
            wr_addr = 6'd60; rd_addr = 6'd61; wr_data = W1; wr_half_en = 2'b11;
            @(negedge clk);
            chk($sformatf("sweep%0d_ctl", i), {sram_cen, sram_gwen, sram_a, wr_req_rdy, rd_req_rdy, init_done},
                {1'b0, 1'b0, 6'(i), 1'b0, 1'b0, 1'b0});
            chk($sformatf("sweep%0d_wen_d", i), {sram_wen, sram_d}, {W0, W0});
            chk($sformatf("sweep%0d_rvld", i), rd_data_vld, 1'(i == vld_at));
            if (i == vld_at) chk($sformatf("sweep%0d_rdata", i), rd_data, vld_data);
            @(posedge clk); #1;
        end
        idle_in();
        @(negedge clk);
        chk("init_done_after_sweep", {init_done, wr_req_rdy, rd_req_rdy, sram_cen}, 4'b1111);
        @(posedge clk); #1;
    endtask

    // Read one address and check the response two cycles later.
    task automatic rd_expect(input logic [5:0] addr, input logic [87:0] exp);
        idle_in(); rd_req_vld = 1'b1; rd_addr = addr;
        @(negedge clk);
        chk("rdx_fire", {rd_req_rdy, sram_cen, sram_gwen, sram_a}, {1'b1, 1'b0, 1'b1, addr});
        @(posedge clk); #1; idle_in();
        @(negedge clk); chk("rdx_early", rd_data_vld, 1'b0);
        @(posedge clk); #1;
        @(negedge clk); chk("rdx_vld", rd_data_vld, 1'b1); chk("rdx_data", rd_data, exp);
        @(posedge clk); #1;
    endtask

    task automatic wr_once(input logic [5:0] addr, input logic [87:0] dat);
        idle_in(); wr_req_vld = 1'b1; wr_addr = addr; wr_data = dat; wr_half_en = 2'b11;
        @(negedge clk);
        chk("wr_fire", {wr_req_rdy, sram_cen, sram_gwen, sram_a, sram_d}, {1'b1, 1'b0, 1'b0, addr, dat});
        @(posedge clk); #1; idle_in();
    endtask

    typedef struct {
        logic wv; logic rv; logic [5:0] wa; logic [87:0] wd; logic [1:0] he; logic [5:0] ra;
        logic e_wrdy; logic e_rrdy; logic e_cen; logic e_gwen; logic [5:0] e_a;
        logic [87:0] e_wen; logic [87:0] e_d; logic e_rvld; logic e_chkr; logic [87:0] e_rdat;
    } vec_t;

    vec_t vec [23];

    function automatic vec_t idle_v(input logic rvld, input logic [87:0] rdat);
        return '{1'b0, 1'b0, 6'd0, W0, 2'd0, 6'd0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd0, W1, W0, rvld, 1'b1, rdat};
    endfunction

    initial begin
        //        wv    rv    wa     wd  he     ra     wrdy  rrdy  cen   gwen  a      wen d   rvld  chkr  rdat
        vec[0]  = idle_v(1'b0, W0);
        vec[1]  = '{1'b1, 1'b0, 6'd5,  DA, 2'd3, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd5,  W0, DA, 1'b0, 1'b0, W0};
        vec[2]  = '{1'b0, 1'b1, 6'd0,  W0, 2'd0, 6'd5, 1'b0, 1'b1, 1'b0, 1'b1, 6'd5,  W1, W0, 1'b0, 1'b0, W0};
        vec[3]  = '{1'b1, 1'b0, 6'd7,  W1, 2'd1, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd7,  HI, W1, 1'b0, 1'b0, W0};
        vec[4]  = '{1'b0, 1'b1, 6'd0,  W0, 2'd0, 6'd7, 1'b0, 1'b1, 1'b0, 1'b1, 6'd7,  W1, W0, 1'b1, 1'b1, DA};
        vec[5]  = idle_v(1'b0, DA);
        vec[6]  = idle_v(1'b1, LO);
        vec[7]  = idle_v(1'b0, LO);
        vec[8]  = '{1'b1, 1'b1, 6'd9,  D9, 2'd2, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0, 6'd9,  LO, D9, 1'b0, 1'b0, W0};
        vec[9]  = '{1'b1, 1'b1, 6'd9,  D9, 2'd2, 6'd5, 1'b0, 1'b1, 1'b0, 1'b1, 6'd5,  W1, W0, 1'b0, 1'b0, W0};
        vec[10] = '{1'b1, 1'b1, 6'd9,  D9, 2'd2, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0, 6'd9,  LO, D9, 1'b0, 1'b0, W0};
        vec[11] = '{1'b1, 1'b1, 6'd9,  D9, 2'd2, 6'd5, 1'b0, 1'b1, 1'b0, 1'b1, 6'd5,  W1, W0, 1'b1, 1'b1, DA};
        vec[12] = idle_v(1'b0, DA);
        vec[13] = idle_v(1'b1, DA);
        vec[14] = '{1'b1, 1'b0, 6'd5,  W1, 2'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd5,  W1, W1, 1'b0, 1'b0, W0};
        vec[15] = '{1'b0, 1'b1, 6'd0,  W0, 2'd0, 6'd5, 1'b0, 1'b1, 1'b0, 1'b1, 6'd5,  W1, W0, 1'b0, 1'b0, W0};
        vec[16] = idle_v(1'b0, DA);
        vec[17] = idle_v(1'b1, DA);
        vec[18] = '{1'b1, 1'b0, 6'd10, D9, 2'd3, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd10, W0, D9, 1'b0, 1'b0, W0};
        vec[19] = '{1'b1, 1'b0, 6'd10, D9, 2'd3, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd10, W0, D9, 1'b0, 1'b0, W0};
        vec[20] = '{1'b0, 1'b1, 6'd0,  W0, 2'd0, 6'd9, 1'b0, 1'b1, 1'b0, 1'b1, 6'd9,  W1, W0, 1'b0, 1'b0, W0};
        vec[21] = idle_v(1'b0, DA);
        vec[22] = idle_v(1'b1, D9 & HI);

        // Reset state while held in reset.
        cpurst_b = 1'b0;
        idle_in();
        #12;
        chk("reset_ctl", {sram_cen, init_done, wr_req_rdy, rd_req_rdy, rd_data_vld}, 5'b10000);
        chk("reset_rdata", rd_data, W0);
        @(posedge clk); #1;
        chk("reset_hold_cen", sram_cen, 1'b1);
        cpurst_b = 1'b1;

        // First sweep with idle requesters; init_req mid-sweep must be ignored.
        do_sweep(10, 1'b0, -1, W0);

        // Directed vector table in RUN.
        for (int k = 0; k < 23; k++) begin
            init_req   = 1'b0;
            wr_req_vld = vec[k].wv; rd_req_vld = vec[k].rv;
            wr_addr = vec[k].wa; wr_data = vec[k].wd; wr_half_en = vec[k].he; rd_addr = vec[k].ra;
            @(negedge clk);
            chk($sformatf("vec%0d_rdy", k), {wr_req_rdy, rd_req_rdy}, {vec[k].e_wrdy, vec[k].e_rrdy});
            chk($sformatf("vec%0d_cen_gwen_a", k), {sram_cen, sram_gwen, sram_a}, {vec[k].e_cen, vec[k].e_gwen, vec[k].e_a});
            chk($sformatf("vec%0d_wen", k), sram_wen, vec[k].e_wen);
            if (vec[k].e_cen || !vec[k].e_gwen) chk($sformatf("vec%0d_d", k), sram_d, vec[k].e_d);
            chk($sformatf("vec%0d_rvld", k), rd_data_vld, vec[k].e_rvld);
            if (vec[k].e_chkr) chk($sformatf("vec%0d_rdata", k), rd_data, vec[k].e_rdat);
            @(posedge clk); #1;
        end
        idle_in();

        // Write addr 3, then init_req together with an accepted read of addr 3.
        wr_once(6'd3, D9);
        rd_req_vld = 1'b1; rd_addr = 6'd3; init_req = 1'b1;
        @(negedge clk);
        chk("ireq_rd_fire", {rd_req_rdy, sram_cen, sram_gwen, sram_a, init_done}, {1'b1, 1'b0, 1'b1, 6'd3, 1'b1});
        @(posedge clk); #1;
        // The in-flight read returns during the re-sweep; requesters held valid see no ready.
        do_sweep(20, 1'b1, 1, D9);
        rd_expect(6'd3, W0);

        // Reset pulse one cycle after a read fire discards the read and restarts the sweep.
        wr_once(6'd5, DA);
        rd_expect(6'd5, DA);
        rd_req_vld = 1'b1; rd_addr = 6'd5;
        @(negedge clk);
        chk("rst_rd_fire", {rd_req_rdy, sram_cen, sram_a}, {1'b1, 1'b0, 6'd5});
        @(posedge clk); #1;
        idle_in();
        cpurst_b = 1'b0;
        #1;
        chk("rst_pulse_ctl", {sram_cen, init_done, wr_req_rdy, rd_req_rdy, rd_data_vld}, 5'b10000);
        chk("rst_pulse_rdata", rd_data, W0);
        #1;
        cpurst_b = 1'b1;
        do_sweep(-1, 1'b0, -1, W0);
        chk("rst_rdata_after_sweep", rd_data, W0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
